// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 68000-style bus-cycle generator: phase
// encoding, strobe levels and the default DTACK timeout.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        STROBE  = 3'd2,
        DSW     = 3'd3,
        WAIT    = 3'd4,
        SAMPLE  = 3'd5,
        RELEASE = 3'd6
    } bus_state_e;

    // Strobes on the 68000 bus are active-low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int DEFAULT_TIMEOUT = 64;

    // Map byte enables {upper, lower} onto the {UDS, LDS} pin levels.
    function automatic logic [1:0] be_to_ds(input logic [1:0] be);
        return {(be[1] ? STROBE_ON : STROBE_OFF), (be[0] ? STROBE_ON : STROBE_OFF)};
    endfunction

endpackage

// File: rtl/cpu_bus_master_timeout.sv
// DTACK wait counter: counts clock-enable ticks while enabled and flags
// when the final allowed tick has been reached.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] r_count;

    // Count enabled ticks, saturating at the expiry value; clear wins.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_bus_master.sv
// Turns single word-transfer commands into 68000 asynchronous bus cycles,
// stepping one bus phase per 7 MHz clock-enable tick.
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              rst_ext,
    input  logic              clk7_en,
    input  logic              cpu_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_be,
    input  logic [15:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] cpu_address,
    output logic [15:0]       cpu_data_out,
    input  logic [15:0]       cpu_data_in,
    output logic              cpu_as,
    output logic              cpu_uds,
    output logic              cpu_lds,
    output logic              cpu_r_w,
    input  logic              cpu_dtack
);

    bus_state_e        r_state;
    logic              r_write;
    logic [ADDR_W-1:1] r_addr;
    logic [1:0]        r_be;
    logic [15:0]       r_wdata;
    logic              r_err;

    logic w_accept;
    logic w_ctr_clr;
    logic w_ctr_en;
    logic w_expired;
    logic w_unused_addr_lsb;

    // Word bus: the byte address LSB is carried by UDS/LDS instead.
    assign w_unused_addr_lsb = cmd_addr[0];

    assign cmd_ready = (r_state == IDLE) & cpu_reset_n & ~rst_ext;
    assign w_accept  = cmd_valid & cmd_ready;

    // The wait counter only runs while DTACK is outstanding in WAIT.
    assign w_ctr_clr = rst_ext | (r_state != WAIT);
    assign w_ctr_en  = clk7_en & (r_state == WAIT) & cpu_dtack;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .i_clr     (w_ctr_clr),
        .i_en      (w_ctr_en),
        .o_expired (w_expired)
    );

    // Bus-cycle sequencer: accept, phase stepping, abort and response.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_be         <= 2'b00;
            r_wdata      <= 16'h0000;
            r_err        <= 1'b0;
            cpu_as       <= STROBE_OFF;
            cpu_uds      <= STROBE_OFF;
            cpu_lds      <= STROBE_OFF;
            cpu_r_w      <= 1'b1;
            cpu_address  <= '0;
            cpu_data_out <= 16'h0000;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if ((r_state != IDLE) && !cpu_reset_n) begin
                // Chipset reset aborts the cycle immediately, not on a tick.
                r_state      <= IDLE;
                cpu_as       <= STROBE_OFF;
                cpu_uds      <= STROBE_OFF;
                cpu_lds      <= STROBE_OFF;
                cpu_r_w      <= 1'b1;
                cpu_data_out <= 16'h0000;
                rsp_valid    <= 1'b1;
                rsp_err      <= 1'b1;
                rsp_rdata    <= 16'h0000;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_write   <= cmd_write;
                            r_addr    <= cmd_addr[ADDR_W-1:1];
                            r_be      <= cmd_be;
                            r_wdata   <= cmd_wdata;
                            r_err     <= 1'b0;
                            rsp_rdata <= 16'h0000;
                            if (cmd_be == 2'b00) begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end else begin
                                r_state <= ADDR;
                            end
                        end
                    end
                    ADDR: begin
                        if (clk7_en) begin
                            cpu_address  <= {r_addr, 1'b0};
                            cpu_r_w      <= ~r_write;
                            cpu_data_out <= r_write ? r_wdata : 16'h0000;
                            r_state      <= STROBE;
                        end
                    end
                    STROBE: begin
                        if (clk7_en) begin
                            cpu_as <= STROBE_ON;
                            if (r_write) begin
                                r_state <= DSW;
                            end else begin
                                {cpu_uds, cpu_lds} <= be_to_ds(r_be);
                                r_state            <= WAIT;
                            end
                        end
                    end
                    DSW: begin
                        if (clk7_en) begin
                            {cpu_uds, cpu_lds} <= be_to_ds(r_be);
                            r_state            <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (clk7_en) begin
                            if (!cpu_dtack) begin
                                r_state <= SAMPLE;
                            end else if (w_expired) begin
                                r_err     <= 1'b1;
                                rsp_rdata <= 16'h0000;
                                r_state   <= RELEASE;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (clk7_en) begin
                            if (!r_write) begin
                                rsp_rdata <= cpu_data_in;
                            end
                            r_state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (clk7_en) begin
                            cpu_as       <= STROBE_OFF;
                            cpu_uds      <= STROBE_OFF;
                            cpu_lds      <= STROBE_OFF;
                            cpu_r_w      <= 1'b1;
                            cpu_data_out <= 16'h0000;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= r_err;
                            r_state      <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Randomised and directed bench for cpu_bus_master against a tick-indexed
// transaction model of the 68000 bus cycle.
module tb_cpu_bus_master;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_ext = 1'b1;
    logic        clk7_en = 1'b0;
    logic        cpu_reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [23:0] cmd_addr = 24'h0;
    logic [1:0]  cmd_be = 2'b00;
    logic [15:0] cmd_wdata = 16'h0;
    logic [15:0] cpu_data_in = 16'h0;
    logic        cpu_dtack = 1'b1;

    logic        cmd_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata, cpu_data_out;
    logic [23:0] cpu_address;
    logic        cpu_as, cpu_uds, cpu_lds, cpu_r_w;

    cpu_bus_master #(.TIMEOUT(TO), .ADDR_W(24)) dut (
        .clk(clk), .rst_ext(rst_ext), .clk7_en(clk7_en), .cpu_reset_n(cpu_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cpu_address(cpu_address), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .cpu_as(cpu_as), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_r_w(cpu_r_w),
        .cpu_dtack(cpu_dtack)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Transaction model: a command is described by the tick index since acceptance.
    bit          m_busy = 1'b0;
    int          m_k, m_end;
    bit          m_w, m_ok;
    logic [23:0] m_addr;
    logic [1:0]  m_be;
    logic [15:0] m_wd, m_cap;
    logic        e_as, e_uds, e_lds, e_rw, e_rv, e_err;
    logic [23:0] e_addr;
    logic [15:0] e_dout, e_rdata;

    // Observation of the DUT for the directed literal checks.
    bit          rand_en = 1'b0;
    int          phase = 0;
    int          lat = 0;
    bit          pend, acc_seen, got_rsp, seen_as, any_uds, any_lds;
    int          r_lat;
    logic        r_err;
    logic [15:0] r_rd;
    logic        fa_uds, fa_lds, fa_rw;
    logic [23:0] fa_addr;
    logic [15:0] fa_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_update();
        int ws;
        e_rv  = 1'b0;
        e_err = 1'b0;
        if (rst_ext) begin
            m_busy = 1'b0;
            e_as = 1'b1; e_uds = 1'b1; e_lds = 1'b1; e_rw = 1'b1;
            e_addr = 24'h0; e_dout = 16'h0; e_rdata = 16'h0;
        end else if (m_busy && !cpu_reset_n) begin
            m_busy = 1'b0;
            e_as = 1'b1; e_uds = 1'b1; e_lds = 1'b1; e_rw = 1'b1; e_dout = 16'h0;
            e_rv = 1'b1; e_err = 1'b1; e_rdata = 16'h0;
        end else if (!m_busy) begin
            if (cmd_valid && cpu_reset_n) begin
                if (cmd_be == 2'b00) begin
                    e_rv = 1'b1; e_err = 1'b1; e_rdata = 16'h0;
                end else begin
                    m_busy = 1'b1; m_k = 0; m_end = -1; m_ok = 1'b0;
                    m_w = cmd_write; m_addr = cmd_addr & 24'hFFFFFE;
                    m_be = cmd_be; m_wd = cmd_wdata;
                end
            end
        end else if (clk7_en) begin
            m_k++;
            ws = m_w ? 4 : 3;
            if (m_k == 1) begin
                e_addr = m_addr; e_rw = ~m_w; e_dout = m_w ? m_wd : 16'h0;
            end
            if (m_k == 2) begin
                e_as = 1'b0;
                if (!m_w) begin e_uds = ~m_be[1]; e_lds = ~m_be[0]; end
            end
            if (m_k == 3 && m_w) begin e_uds = ~m_be[1]; e_lds = ~m_be[0]; end
            if (m_k >= ws && m_end < 0) begin
                if (!cpu_dtack) begin m_end = m_k; m_ok = 1'b1; end
                else if (m_k == ws + TO - 1) begin m_end = m_k; m_ok = 1'b0; end
            end
            if (m_end >= 0 && m_ok && m_k == m_end + 1) m_cap = cpu_data_in;
            if (m_end >= 0 && m_k == m_end + (m_ok ? 2 : 1)) begin
                m_busy = 1'b0;
                e_as = 1'b1; e_uds = 1'b1; e_lds = 1'b1; e_rw = 1'b1; e_dout = 16'h0;
                e_rv = 1'b1; e_err = ~m_ok;
                e_rdata = (m_ok && !m_w) ? m_cap : 16'h0;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        logic en_edge;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, !m_busy && cpu_reset_n && !rst_ext);
        chk("cpu_as", cpu_as, e_as);
        chk("cpu_uds", cpu_uds, e_uds);
        chk("cpu_lds", cpu_lds, e_lds);
        chk("cpu_r_w", cpu_r_w, e_rw);
        chk("cpu_address", cpu_address, e_addr);
        chk("cpu_data_out", cpu_data_out, e_dout);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
            chk("rsp_err", rsp_err, e_err);
            chk("rsp_rdata", rsp_rdata, e_rdata);
        end
        pend = cmd_valid && cmd_ready;
        if (pend) acc_seen = 1'b1;
        if (rsp_valid) begin got_rsp = 1'b1; r_lat = lat; r_err = rsp_err; r_rd = rsp_rdata; end
        if (!cpu_as && !seen_as) begin
            seen_as = 1'b1; fa_uds = cpu_uds; fa_lds = cpu_lds; fa_rw = cpu_r_w;
            fa_addr = cpu_address; fa_dout = cpu_data_out;
        end
        if (!cpu_uds) any_uds = 1'b1;
        if (!cpu_lds) any_lds = 1'b1;
        @(posedge clk);
        en_edge = clk7_en;
        model_update();
        #1;
        if (pend) lat = 0;
        else if (en_edge) lat++;
        clk7_en = rand_en ? ($urandom % 3 == 0) : (phase % 4 == 3);
        phase++;
    endtask

    task automatic issue(input logic w, input logic [23:0] a, input logic [1:0] be, input logic [15:0] wd);
        acc_seen = 1'b0; got_rsp = 1'b0; seen_as = 1'b0; any_uds = 1'b0; any_lds = 1'b0;
        cmd_write = w; cmd_addr = a; cmd_be = be; cmd_wdata = wd; cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !acc_seen; i++) tick();
        cmd_valid = 1'b0;
        chk("accept", acc_seen, 1'b1);
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (n < budget && !got_rsp) begin tick(); n++; end
        chk("rsp_arrived", got_rsp, 1'b1);
    endtask

    initial begin
        int n;
        int rn_hold = 0;
        repeat (3) @(posedge clk);
        model_update();
        #1;
        chk("rst_as", cpu_as, 1'b1);
        chk("rst_ds", {cpu_uds, cpu_lds}, 2'b11);
        chk("rst_rw", cpu_r_w, 1'b1);
        chk("rst_addr", cpu_address, 24'h0);
        chk("rst_dout", cpu_data_out, 16'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'h0);
        chk("rst_ready", cmd_ready, 1'b0);
        rst_ext = 1'b0;
        repeat (4) tick();

        // Read with DTACK already low.
        cpu_dtack = 1'b0; cpu_data_in = 16'h1234;
        issue(1'b0, 24'hDFF004, 2'b11, 16'h0); wait_rsp(400, n);
        chk("rd_lat", r_lat, 5);
        chk("rd_data", r_rd, 16'h1234);
        chk("rd_err", r_err, 1'b0);
        chk("rd_ds_with_as", {fa_uds, fa_lds}, 2'b00);
        chk("rd_addr", fa_addr, 24'hDFF004);
        chk("rd_rw", fa_rw, 1'b1);

        // Upper-byte write.
        issue(1'b1, 24'h000100, 2'b10, 16'hBEEF); wait_rsp(400, n);
        chk("wr_lat", r_lat, 6);
        chk("wr_err", r_err, 1'b0);
        chk("wr_rdata", r_rd, 16'h0);
        chk("wr_rw", fa_rw, 1'b0);
        chk("wr_uds_late", fa_uds, 1'b1);
        chk("wr_dout", fa_dout, 16'hBEEF);
        chk("wr_addr", fa_addr, 24'h000100);
        chk("wr_strobes", {any_uds, any_lds}, 2'b10);

        // DTACK never arrives: timeout after TO WAIT ticks.
        cpu_dtack = 1'b1;
        issue(1'b0, 24'h000200, 2'b11, 16'h0); wait_rsp(1000, n);
        chk("to_lat", r_lat, 2 + TO + 1);
        chk("to_err", r_err, 1'b1);
        chk("to_rdata", r_rd, 16'h0);
        chk("to_as_released", cpu_as, 1'b1);
        cpu_dtack = 1'b0; cpu_data_in = 16'h5A5A;
        issue(1'b0, 24'h000202, 2'b11, 16'h0); wait_rsp(400, n);
        chk("after_to_data", r_rd, 16'h5A5A);
        chk("after_to_lat", r_lat, 5);

        // Odd byte address, lower lane only.
        cpu_data_in = 16'h00C3;
        issue(1'b0, 24'h000101, 2'b01, 16'h0); wait_rsp(400, n);
        chk("odd_addr", fa_addr, 24'h000100);
        chk("odd_strobes", {any_uds, any_lds}, 2'b01);
        chk("odd_data", r_rd, 16'h00C3);

        // Chipset reset while waiting for DTACK.
        cpu_dtack = 1'b1;
        issue(1'b0, 24'h000300, 2'b11, 16'h0);
        for (int i = 0; i < 100 && !seen_as; i++) tick();
        repeat (8) tick();
        cpu_reset_n = 1'b0;
        tick();
        tick();
        chk("crst_rsp", got_rsp, 1'b1);
        chk("crst_err", r_err, 1'b1);
        chk("crst_strobes", {cpu_as, cpu_uds, cpu_lds}, 3'b111);
        repeat (3) tick();
        chk("crst_not_ready", cmd_ready, 1'b0);
        cpu_reset_n = 1'b1;
        tick();

        // External reset while the strobe phase is pending.
        issue(1'b0, 24'h000400, 2'b11, 16'h0);
        for (int i = 0; i < 100 && cpu_address != 24'h000400; i++) tick();
        rst_ext = 1'b1;
        tick();
        rst_ext = 1'b0;
        chk("srst_addr", cpu_address, 24'h0);
        chk("srst_ctrl", {cpu_as, cpu_uds, cpu_lds, cpu_r_w}, 4'hF);
        repeat (6) tick();
        chk("srst_no_rsp", got_rsp, 1'b0);

        // Empty byte enables: error on the next clock, no bus activity.
        issue(1'b0, 24'h000500, 2'b00, 16'h0); wait_rsp(10, n);
        chk("be0_delay", n, 1);
        chk("be0_err", r_err, 1'b1);
        repeat (8) tick();
        chk("be0_no_as", seen_as, 1'b0);

        // Randomised traffic checked cycle by cycle against the model.
        rand_en = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            cmd_valid   = ($urandom % 2 == 0);
            cmd_write   = ($urandom % 2 == 0);
            cmd_addr    = 24'($urandom);
            cmd_be      = 2'($urandom);
            cmd_wdata   = 16'($urandom);
            cpu_data_in = 16'($urandom);
            cpu_dtack   = (c < 3000) ? ($urandom % 5 >= 2) : ($urandom % 40 != 0);
            rst_ext     = ($urandom % 700 == 0);
            if (rn_hold == 0 && $urandom % 250 == 0) rn_hold = $urandom_range(1, 6);
            cpu_reset_n = (rn_hold == 0);
            if (rn_hold > 0) rn_hold--;
            tick();
        end
        cmd_valid = 1'b0; rst_ext = 1'b0; cpu_reset_n = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
